// File: rtl/dmem_responder.sv
// Word-addressed data-memory slave with WAIT wait states and valid/ready request/response channels.
// Optional DMEM_ADDR_CHECK_EN flags addresses >= DEPTH as errors; otherwise addresses wrap modulo DEPTH.
module dmem_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int WAIT   = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept, commit, in_range, mem_we;
  logic                c_we;
  logic [ADDR_W-1:0]   c_addr;
  logic [DATA_W-1:0]   c_wdata, mem_rd, cap_rdata;
  logic [IDX_W-1:0]    idx;
  logic                cap_err;
  logic                addr_unused;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With WAIT=0 the commit happens on the accepting edge, so the live request is used.
  always_comb begin
    accept  = req_valid && (state_q == S_IDLE);
    commit  = (accept && (WAIT == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd0));
    c_we    = (state_q == S_IDLE) ? req_we    : we_q;
    c_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    c_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    idx     = c_addr[IDX_W-1:0];
    addr_unused = ^c_addr;
`ifdef DMEM_ADDR_CHECK_EN
    in_range = ({1'b0, c_addr} < (ADDR_W+1)'(DEPTH));
    cap_err  = !in_range;
`else
    in_range = 1'b1;
    cap_err  = 1'b0;
`endif
    mem_rd    = mem[idx];
    cap_rdata = (!c_we && in_range) ? mem_rd : '0;
    // Rst gating keeps a commit from landing while reset is held.
    mem_we    = commit && c_we && in_range && Rst;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT == 0) begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
            rdata_d = cap_rdata;
            err_d   = cap_err;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          rdata_d = cap_rdata;
          err_d   = cap_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately left without reset.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[idx] <= c_wdata;
  end

endmodule
